// File: rtl/note_sequencer.sv
// note_sequencer: song-level controller that sequences note_player.
// Walks a synchronous song ROM one entry at a time, hands each note and
// duration to note_player with a single-cycle load strobe, then waits for
// done_with_note before fetching the next entry.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   play             level: 1 play/resume, 0 pause
//   song             song select
//   rom_addr         {song_reg, note_idx} to the song ROM
//   rom_data         ROM read data one cycle after rom_addr; [11:6] note, [5:0] duration
//   note_to_load     note for note_player (0 = rest)
//   duration_to_load duration in beats for note_player
//   load_new_note    single-cycle load strobe
//   done_with_note   single-cycle pulse from note_player
//   play_enable      run/pause to note_player (follows play only while PLAYING)
//   song_done        high while in END
//   note_idx         index of the current note
module note_sequencer #(
    parameter int unsigned SONG_W = 2,
    parameter int unsigned NOTE_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic [SONG_W-1:0]        song,
    output logic [SONG_W+NOTE_W-1:0] rom_addr,
    input  logic [11:0]              rom_data,
    output logic [5:0]               note_to_load,
    output logic [5:0]               duration_to_load,
    output logic                     load_new_note,
    input  logic                     done_with_note,
    output logic                     play_enable,
    output logic                     song_done,
    output logic [NOTE_W-1:0]        note_idx
);

    localparam int unsigned FIELD_W = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        LOAD    = 3'd3,
        PLAYING = 3'd4,
        END     = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [SONG_W-1:0]   song_reg;
    logic [SONG_W-1:0]   song_reg_next;
    logic [NOTE_W-1:0]   note_idx_next;
    logic [FIELD_W-1:0]  note_next;
    logic [FIELD_W-1:0]  dur_next;
    logic                song_change;

    assign rom_addr    = {song_reg, note_idx};
    assign song_change = (song != song_reg);

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            song_reg         <= '0;
            note_idx         <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            load_new_note    <= 1'b0;
            song_done        <= 1'b0;
        end else begin
            state            <= state_next;
            song_reg         <= song_reg_next;
            note_idx         <= note_idx_next;
            note_to_load     <= note_next;
            duration_to_load <= dur_next;
            // Strobe and done flag are registered versions of the next state
            load_new_note    <= (state_next == LOAD);
            song_done        <= (state_next == END);
        end
    end

    // Next-state and play_enable logic
    always_comb begin
        state_next    = state;
        song_reg_next = song_reg;
        note_idx_next = note_idx;
        note_next     = note_to_load;
        dur_next      = duration_to_load;
        play_enable   = 1'b0;

        unique case (state)
            IDLE: begin
                note_idx_next = '0;
                song_reg_next = song;
                if (play) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = WAIT;
            end
            WAIT: begin
                note_next = rom_data[11:6];
                dur_next  = rom_data[5:0];
                // Zero duration marks end of song
                if (rom_data[5:0] == '0) begin
                    state_next = END;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = PLAYING;
            end
            PLAYING: begin
                play_enable = play;
                if (done_with_note) begin
                    if (&note_idx) begin
                        state_next = END;
                    end else begin
                        note_idx_next = note_idx + NOTE_W'(1);
                        state_next    = FETCH;
                    end
                end
            end
            END: begin
                if (!play) begin
                    state_next    = IDLE;
                    note_idx_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Song change aborts from anywhere but IDLE and overrides any advance
        if ((state != IDLE) && song_change) begin
            state_next    = IDLE;
            note_idx_next = '0;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Testbench for note_sequencer: ROM model, scoreboard of expected loads,
// latency, pause, song change, full-length song and mid-song reset.
module tb_note_sequencer;

    localparam int unsigned SONG_W = 2;
    localparam int unsigned NOTE_W = 5;
    localparam int unsigned ADDR_W = SONG_W + NOTE_W;

    logic              clk;
    logic              reset;
    logic              play;
    logic [SONG_W-1:0] song;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [5:0]        note_to_load;
    logic [5:0]        duration_to_load;
    logic              load_new_note;
    logic              done_with_note;
    logic              play_enable;
    logic              song_done;
    logic [NOTE_W-1:0] note_idx;

    logic [11:0] rom [0:(1<<ADDR_W)-1];
    logic [11:0] exp_q [$];
    int          checks;
    int          failures;
    int          load_count;

    note_sequencer #(.SONG_W(SONG_W), .NOTE_W(NOTE_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .done_with_note   (done_with_note),
        .play_enable      (play_enable),
        .song_done        (song_done),
        .note_idx         (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous song ROM
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every observed load strobe must match the next expected entry
    always @(negedge clk) begin
        logic [11:0] e;
        if (load_new_note === 1'b1) begin
            load_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_load", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("load_note", 32'(note_to_load), 32'(e[11:6]));
                check("load_dur", 32'(duration_to_load), 32'(e[5:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until the load strobe is visible, bounded
    task automatic wait_load(input string tag, output int n);
        n = 0;
        while (load_new_note !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        if (load_new_note !== 1'b1) check({tag, "_timeout"}, 32'(0), 32'(1));
    endtask

    // One done pulse, then edges until the next strobe (total count includes the pulse edge)
    task automatic done_then_load(input string tag, output int n);
        int m;
        done_with_note = 1'b1;
        tick();
        done_with_note = 1'b0;
        wait_load(tag, m);
        n = m + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        checks = 0; failures = 0; load_count = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = {6'(i), 6'd1};
        // Song 0: (5,5) (7,3) (0,2) end
        rom[0] = {6'd5, 6'd5}; rom[1] = {6'd7, 6'd3};
        rom[2] = {6'd0, 6'd2}; rom[3] = {6'd9, 6'd0};
        // Song 1: all 32 slots nonzero
        for (int i = 0; i < 32; i++) rom[32 + i] = {6'(i + 1), 6'((i % 7) + 1)};
        // Song 2
        rom[64] = {6'd11, 6'd4}; rom[65] = {6'd12, 6'd1}; rom[66] = {6'd0, 6'd0};

        reset = 1'b0; play = 1'b0; song = '0; done_with_note = 1'b0;
        tick(); tick();
        check("rst_idx", 32'(note_idx), 32'(0));
        check("rst_load", 32'(load_new_note), 32'(0));
        check("rst_pe", 32'(play_enable), 32'(0));
        check("rst_done", 32'(song_done), 32'(0));
        check("rst_note", 32'(note_to_load), 32'(0));
        check("rst_dur", 32'(duration_to_load), 32'(0));
        reset = 1'b1;
        tick();

        // Song 0 with a pause on the first note
        exp_q.push_back({6'd5, 6'd5});
        exp_q.push_back({6'd7, 6'd3});
        exp_q.push_back({6'd0, 6'd2});
        play = 1'b1;
        wait_load("play_lat", n);
        check("lat_play", 32'(n), 32'(3));
        tick();
        check("playing_pe", 32'(play_enable), 32'(1));
        play = 1'b0;
        #1;
        for (int c = 0; c < 20; c++) begin
            check("pause_pe", 32'(play_enable), 32'(0));
            check("pause_load", 32'(load_new_note), 32'(0));
            tick();
        end
        play = 1'b1;
        #1;
        check("resume_pe", 32'(play_enable), 32'(1));
        check("resume_idx", 32'(note_idx), 32'(0));
        done_then_load("done_lat", n);
        check("lat_done", 32'(n), 32'(3));
        check("idx1", 32'(note_idx), 32'(1));
        tick();
        done_then_load("note2", n);
        check("idx2", 32'(note_idx), 32'(2));
        tick();
        done_with_note = 1'b1;
        tick();
        done_with_note = 1'b0;
        tick(); tick();
        check("s0_done", 32'(song_done), 32'(1));
        check("s0_end_pe", 32'(play_enable), 32'(0));
        check("s0_end_idx", 32'(note_idx), 32'(3));
        repeat (5) tick();
        check("s0_hold_done", 32'(song_done), 32'(1));
        check("s0_loads", 32'(load_count), 32'(3));
        play = 1'b0;
        tick();
        check("end_idle_done", 32'(song_done), 32'(0));
        check("end_idle_idx", 32'(note_idx), 32'(0));

        // Song change with simultaneous done
        exp_q.push_back({6'd5, 6'd5});
        exp_q.push_back({6'd7, 6'd3});
        play = 1'b1;
        wait_load("sc_first", n);
        tick();
        done_then_load("sc_second", n);
        tick();
        check("sc_pre_idx", 32'(note_idx), 32'(1));
        song = 2'd2;
        done_with_note = 1'b1;
        tick();
        done_with_note = 1'b0;
        check("sc_idx", 32'(note_idx), 32'(0));
        check("sc_load", 32'(load_new_note), 32'(0));
        check("sc_pe", 32'(play_enable), 32'(0));
        exp_q.push_back({6'd11, 6'd4});
        tick();
        check("sc_rom_addr", 32'(rom_addr), 32'(64));
        wait_load("sc_song2", n);
        check("sc_lat", 32'(n), 32'(2));
        tick();

        // Full 32-slot song
        base = load_count;
        for (int i = 0; i < 32; i++) exp_q.push_back({6'(i + 1), 6'((i % 7) + 1)});
        song = 2'd1;
        tick();
        for (int i = 0; i < 32; i++) begin
            wait_load("long", n);
            check("long_idx", 32'(note_idx), 32'(i));
            tick();
            done_with_note = 1'b1;
            tick();
            done_with_note = 1'b0;
        end
        check("long_done", 32'(song_done), 32'(1));
        check("long_idx_end", 32'(note_idx), 32'(31));
        repeat (4) tick();
        check("long_idx_hold", 32'(note_idx), 32'(31));
        check("long_loads", 32'(load_count - base), 32'(32));

        // Reset asserted in LOAD
        play = 1'b0;
        song = 2'd0;
        tick(); tick();
        play = 1'b1;
        n = 0;
        while (load_new_note !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        reset = 1'b0;
        #1;
        check("rl_load", 32'(load_new_note), 32'(0));
        check("rl_idx", 32'(note_idx), 32'(0));
        check("rl_note", 32'(note_to_load), 32'(0));
        check("rl_dur", 32'(duration_to_load), 32'(0));
        check("rl_addr", 32'(rom_addr), 32'(0));
        tick(); tick();
        reset = 1'b1;
        exp_q.push_back({6'd5, 6'd5});
        wait_load("rl_restart", n);
        check("rl_lat", 32'(n), 32'(3));
        check("rl_restart_idx", 32'(note_idx), 32'(0));
        tick(); tick();
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
